adc_seq_ctrl: RTL and testbench

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

---
 rtl/adc_seq_ctrl_pkg.sv | 31 +++
 rtl/adc_seq_ctrl_avg.sv | 88 ++++++++
 rtl/adc_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_ctrl_pkg.sv
// Shared types and CSR layout for the ADC sequencer controller.
// Optional averaging is enabled with the ADC_SEQ_CTRL_AVG_EN macro.
package adc_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_RUN,
        S_RD_RUN,
        S_RUNNING,
        S_WR_HALT,
        S_FAULT
    } state_t;

    localparam int CSR_RUN_BIT  = 0;
    localparam int CSR_MODE_LSB = 1;
    localparam int CSR_MODE_MSB = 3;

    localparam logic [2:0] CSR_MODE_CONTINUOUS = 3'd0;

    function automatic logic [15:0] csr_word(input logic run, input logic [2:0] mode);
        logic [15:0] w;
        w = '0;
        w[CSR_RUN_BIT] = run;
        w[CSR_MODE_MSB:CSR_MODE_LSB] = mode;
        return w;
    endfunction

    localparam logic [15:0] CSR_RUN_WORD  = csr_word(1'b1, CSR_MODE_CONTINUOUS);
    localparam logic [15:0] CSR_HALT_WORD = 16'h0000;

endpackage

// File: rtl/adc_seq_ctrl_avg.sv
// Per-channel averaging bank and result register (module adc_ch_avg).
// Averaging is built only with ADC_SEQ_CTRL_AVG_EN; otherwise samples pass through registered.
module adc_ch_avg
    import adc_seq_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [4:0]  in_channel,
    input  logic [11:0] in_data,
    output logic        out_valid,
    output logic [4:0]  out_channel,
    output logic [11:0] out_data
);

`ifdef ADC_SEQ_CTRL_AVG_EN
    localparam int AW  = 12 + AVG_LOG2;
    localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]  acc [NUM_CH];
    logic [CW-1:0]  cnt [NUM_CH];
    logic [CHW-1:0] ch_idx;
    logic [AW-1:0]  sum;
    logic           last;

    assign ch_idx = in_channel[CHW-1:0];
    assign sum    = acc[ch_idx] + AW'(in_data);
    assign last   = (cnt[ch_idx] == CNT_LAST);

    // NOTE: the bank is flops, not RAM, so it can be reset and bulk-cleared in one cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
            end else if (in_valid) begin
                if (last) begin
                    // The completing sample is folded in here, so the next one starts a fresh sum.
                    acc[ch_idx] <= '0;
                    cnt[ch_idx] <= '0;
                    out_valid   <= 1'b1;
                    out_channel <= in_channel;
                    out_data    <= sum[AVG_LOG2 +: 12];
                end else begin
                    acc[ch_idx] <= sum;
                    cnt[ch_idx] <= cnt[ch_idx] + CW'(1);
                end
            end
        end
    end
`else
    // Geometry parameters have no effect on the pass-through path.
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(AVG_LOG2 + NUM_CH);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
        end else begin
            out_valid <= in_valid && !clr;
            if (in_valid) begin
                out_channel <= in_channel;
                out_data    <= in_data;
            end
        end
    end
`endif

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC sequencer controller: CSR run/halt handshake over an Avalon-MM master plus result stream.
// Define ADC_SEQ_CTRL_AVG_EN to average 2^AVG_LOG2 samples per channel before output.
module adc_seq_ctrl
    import adc_seq_ctrl_pkg::*;
#(
    parameter int         NUM_CH   = 8,
    parameter int         AVG_LOG2 = 2,
    parameter logic [9:0] CSR_ADDR = 10'h000,
    parameter int         TMO_CYC  = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic        stop,
    output logic        running,
    output logic        busy,
    output logic        err,
    output logic [9:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [15:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        rsp_valid,
    input  logic [4:0]  rsp_channel,
    input  logic [11:0] rsp_data,
    output logic        out_valid,
    output logic [4:0]  out_channel,
    output logic [11:0] out_data
);

    localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t        state, state_nxt;
    logic          rd_pending;
    logic [TW-1:0] tmo_cnt;
    logic          start_ok;
    logic          sample_ok;
    logic          unused_rd;

    assign start_ok  = (state == S_IDLE) && start && !stop;
    assign running   = (state == S_RUNNING);
    assign busy      = (state == S_WR_RUN) || (state == S_RD_RUN) || (state == S_WR_HALT);
    assign sample_ok = running && rsp_valid && (32'(rsp_channel) < 32'(NUM_CH));
    assign unused_rd = ^avm_readdata[15:1];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= S_IDLE;
            rd_pending <= 1'b0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == S_RD_RUN) && !rd_pending && !avm_waitrequest)
                rd_pending <= 1'b1;
            else if (state_nxt != S_RD_RUN)
                rd_pending <= 1'b0;

            // Counts cycles waited since read acceptance; value is (cycles waited - 1).
            if ((state == S_RD_RUN) && rd_pending)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;

            if (start_ok)
                err <= 1'b0;
            else if (state == S_FAULT)
                err <= 1'b1;
        end
    end

    // NOTE: every output is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nxt      = state;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = 2'b11;

        case (state)
            S_IDLE: begin
                if (start_ok)
                    state_nxt = S_WR_RUN;
            end
            S_WR_RUN: begin
                avm_write     = 1'b1;
                avm_address   = CSR_ADDR;
                avm_writedata = CSR_RUN_WORD;
                if (!avm_waitrequest)
                    state_nxt = S_RD_RUN;
            end
            S_RD_RUN: begin
                avm_address = CSR_ADDR;
                if (!rd_pending)
                    avm_read = 1'b1;
                else if (avm_readdatavalid)
                    state_nxt = avm_readdata[CSR_RUN_BIT] ? S_RUNNING : S_FAULT;
                else if (tmo_cnt == TMO_LAST)
                    state_nxt = S_FAULT;
            end
            S_RUNNING: begin
                if (stop)
                    state_nxt = S_WR_HALT;
            end
            S_WR_HALT: begin
                avm_write     = 1'b1;
                avm_address   = CSR_ADDR;
                avm_writedata = CSR_HALT_WORD;
                if (!avm_waitrequest)
                    state_nxt = S_IDLE;
            end
            S_FAULT: begin
                state_nxt = S_WR_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Holding the bank clear outside RUNNING both resets it on entry and drops partial sums on exit.
    adc_ch_avg #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .clr         (!running),
        .in_valid    (sample_ok),
        .in_channel  (rsp_channel),
        .in_data     (rsp_data),
        .out_valid   (out_valid),
        .out_channel (out_channel),
        .out_data    (out_data)
    );

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl: Avalon slave model, sample reference model, result monitor.
// Expects averaging when ADC_SEQ_CTRL_AVG_EN is defined, pass-through otherwise.
module tb_adc_seq_ctrl;

    localparam int         NUM_CH   = 8;
    localparam int         AVG_LOG2 = 2;
    localparam logic [9:0] CSR      = 10'h2A4;
    localparam int         TMO      = 20;

    logic        clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic        running, busy, err;
    logic [9:0]  avm_address;
    logic        avm_write, avm_read;
    logic [15:0] avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [4:0]  rsp_channel = '0;
    logic [11:0] rsp_data = '0;
    logic        out_valid;
    logic [4:0]  out_channel;
    logic [11:0] out_data;

    always #5 clk = ~clk;

    adc_seq_ctrl #(
        .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2), .CSR_ADDR(CSR), .TMO_CYC(TMO)
    ) dut (
        .clk_clk(clk), .reset_reset(reset_reset), .start(start), .stop(stop),
        .running(running), .busy(busy), .err(err),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [4:0] ch; logic [11:0] data; int due; } out_t;
    typedef struct { logic [9:0] addr; logic [15:0] data; } wr_t;
    out_t out_q[$];
    wr_t  wr_q[$];

    // Bridge slave behaviour, changed by the main sequence between scenarios.
    int          wr_wait = 0, rd_wait = 0, rd_delay = 1;
    logic [15:0] rd_value = 16'h0001;
    int          wr_count = 0, rd_count = 0;
    int          rd_acc_cyc = 0, wr_start_cyc = 0;

    initial begin
        int stall = 0;
        int cd = 0;
        logic prev_write = 1'b0;
        forever begin
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            if (avm_write && !prev_write) wr_start_cyc = cyc;
            prev_write = avm_write;
            if (reset_reset) begin
                stall = 0;
                cd = 0;
                avm_waitrequest = 1'b0;
                continue;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = rd_value;
                end
            end
            if (avm_write) begin
                check("wr_expected", 32'(wr_q.size() > 0), 1);
                if (wr_q.size() > 0) begin
                    check("wr_addr", 32'(avm_address), 32'(wr_q[0].addr));
                    check("wr_data", 32'(avm_writedata), 32'(wr_q[0].data));
                    check("wr_be", 32'(avm_byteenable), 32'h3);
                end
            end
            if (avm_read) check("rd_addr", 32'(avm_address), 32'(CSR));
            if (avm_write || avm_read) begin
                if (stall < (avm_write ? wr_wait : rd_wait)) begin
                    avm_waitrequest = 1'b1;
                    stall++;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall = 0;
                    if (avm_write) begin
                        if (wr_q.size() > 0) void'(wr_q.pop_front());
                        wr_count++;
                    end else begin
                        rd_count++;
                        rd_acc_cyc = cyc;
                        cd = rd_delay;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall = 0;
            end
        end
    end

    // Result monitor: every out_valid must match the oldest expected result and its due cycle.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("out_expected", 32'(out_q.size() > 0), 1);
                if (out_q.size() > 0) begin
                    e = out_q.pop_front();
                    check("out_channel", 32'(out_channel), 32'(e.ch));
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Reference model: per-channel running sums, valid only while the bench has seen RUNNING.
    bit model_running = 0;
    int m_sum[32];
    int m_cnt[32];

    task automatic send(input logic v, input logic [4:0] ch, input logic [11:0] d);
        rsp_valid = v;
        rsp_channel = ch;
        rsp_data = d;
        if (v && model_running && int'(ch) < NUM_CH) begin
`ifdef ADC_SEQ_CTRL_AVG_EN
            m_sum[ch] += int'(d);
            m_cnt[ch]++;
            if (m_cnt[ch] == (1 << AVG_LOG2)) begin
                out_q.push_back('{ch, 12'(m_sum[ch] / (1 << AVG_LOG2)), cyc + 1});
                m_sum[ch] = 0;
                m_cnt[ch] = 0;
            end
`else
            out_q.push_back('{ch, d, cyc + 1});
`endif
        end
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_running(input int budget);
        int n = 0;
        while (!running && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_running", 32'(running), 1);
        for (int i = 0; i < 32; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
        end
        model_running = 1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(!busy && !running && wr_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reach_idle", 32'(!busy && !running && wr_q.size() == 0), 1);
    endtask

    task automatic halt_run();
        model_running = 0;
        wr_q.push_back('{CSR, 16'h0000});
        pulse_stop();
        wait_idle(50);
    endtask

    initial begin
        int w0;
        @(negedge clk);
        check("rst_running", 32'(running), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_write", 32'(avm_write), 0);
        check("rst_read", 32'(avm_read), 0);
        check("rst_address", 32'(avm_address), 0);
        check("rst_writedata", 32'(avm_writedata), 0);
        check("rst_be", 32'(avm_byteenable), 32'h3);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_channel", 32'(out_channel), 0);
        check("rst_out_data", 32'(out_data), 0);
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        @(negedge clk);

        // Start with a stalled write and a delayed readback of run=1.
        wr_wait = 3; rd_wait = 1; rd_delay = 2; rd_value = 16'h0001;
        w0 = wr_count;
        wr_q.push_back('{CSR, 16'h0001});
        pulse_start();
        wait_running(60);
        check("run_busy", 32'(busy), 0);
        check("run_err", 32'(err), 0);
        check("run_writes", 32'(wr_count - w0), 1);
        wr_wait = 0; rd_wait = 0; rd_delay = 1;

        // Directed average, a pass-through probe, and out-of-range channels.
        send(1, 5'd3, 12'd100);
        send(1, 5'd3, 12'd101);
        send(1, 5'd3, 12'd102);
        send(1, 5'd3, 12'd104);
        send(1, 5'd0, 12'hABC);
        send(1, 5'd9, 12'h111);
        send(1, 5'd8, 12'h222);
        repeat (3) @(negedge clk);

        w0 = wr_count;
        pulse_start();
        repeat (3) @(negedge clk);
        check("start_in_running", 32'(running), 1);
        check("start_in_running_writes", 32'(wr_count - w0), 0);

        for (int i = 0; i < 300; i++)
            send(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 11)), 12'($urandom));
        send(1, 5'd5, 12'd4000);
        send(1, 5'd5, 12'd4000);
        repeat (3) @(negedge clk);
        halt_run();
        check("halt_err", 32'(err), 0);

        // Samples while idle are dropped; simultaneous start+stop is ignored.
        for (int i = 0; i < 8; i++) send(1, 5'd1, 12'($urandom));
        w0 = wr_count;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (4) @(negedge clk);
        check("start_stop_busy", 32'(busy), 0);
        check("start_stop_writes", 32'(wr_count - w0), 0);

        // Restart with readback on the last permitted cycle; old partial sums must be gone.
        rd_delay = TMO;
        wr_q.push_back('{CSR, 16'h0001});
        pulse_start();
        wait_running(TMO + 20);
        check("late_rd_err", 32'(err), 0);
        rd_delay = 1;
        send(1, 5'd5, 12'd8);
        send(1, 5'd5, 12'd8);
        send(1, 5'd5, 12'd8);
        send(1, 5'd5, 12'd9);
        repeat (3) @(negedge clk);
        halt_run();

        // Readback with run=0 faults and halts; next start clears err.
        rd_value = 16'h0000;
        w0 = wr_count;
        wr_q.push_back('{CSR, 16'h0001});
        wr_q.push_back('{CSR, 16'h0000});
        pulse_start();
        wait_idle(60);
        check("rb_fault_err", 32'(err), 1);
        check("rb_fault_writes", 32'(wr_count - w0), 2);
        check("rb_fault_latency", 32'(wr_start_cyc - rd_acc_cyc), 3);
        rd_value = 16'h0001;
        wr_q.push_back('{CSR, 16'h0001});
        pulse_start();
        check("restart_err_clear", 32'(err), 0);
        check("restart_busy", 32'(busy), 1);
        wait_running(30);
        halt_run();

        // Readback never arrives: timeout fault.
        rd_delay = 0;
        w0 = wr_count;
        wr_q.push_back('{CSR, 16'h0001});
        wr_q.push_back('{CSR, 16'h0000});
        pulse_start();
        wait_idle(TMO + 40);
        check("tmo_err", 32'(err), 1);
        check("tmo_writes", 32'(wr_count - w0), 2);
        check("tmo_latency", 32'(wr_start_cyc - rd_acc_cyc), 32'(TMO + 2));
        rd_delay = 1;

        // Reset while the run write is stalled: abandoned, no halt write.
        wr_wait = 50;
        wr_q.push_back('{CSR, 16'h0001});
        pulse_start();
        @(negedge clk);
        check("pre_rst_write", 32'(avm_write), 1);
        reset_reset = 1'b1;
        @(negedge clk);
        check("mid_rst_write", 32'(avm_write), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err), 0);
        reset_reset = 1'b0;
        wr_q.delete();
        wr_wait = 0;
        w0 = wr_count;
        repeat (5) @(negedge clk);
        check("post_rst_writes", 32'(wr_count - w0), 0);
        check("post_rst_running", 32'(running), 0);

        repeat (3) @(negedge clk);
        check("results_drained", 32'(out_q.size()), 0);
        check("writes_drained", 32'(wr_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
